// File: rtl/section1_pkg.sv
// Shared types and constants for the section 1 a0 divide sequencer.
// Output decode lives here so the FSM stays a pure next-state block.
package section1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    SUB,
    DONE
  } s1_state_t;

  localparam logic [15:0] S1_MAX_ITER_DEFAULT = 16'hFFFF;

  localparam logic MUX_SEL_A0_IN = 1'b0;
  localparam logic MUX_SEL_REG   = 1'b1;
  localparam logic MUX_SEL_SUB   = 1'b1;

  typedef struct packed {
    logic ctrl1;
    logic ctrl2;
    logic ctrl6;
    logic ctrl7;
    logic busy;
    logic done;
  } s1_out_t;

  function automatic s1_out_t s1_decode(
    input s1_state_t st,
    input logic      src
  );
    s1_out_t o;
    o = '0;
    unique case (st)
      LOAD: begin
        o.ctrl1 = src;
        o.ctrl2 = 1'b0;
        o.ctrl7 = 1'b1;
      end
      SUB: begin
        o.ctrl1 = src;
        o.ctrl2 = MUX_SEL_SUB;
        o.ctrl7 = 1'b1;
      end
      DONE: begin
        o.ctrl6 = 1'b1;
        o.done  = 1'b1;
      end
      default: o = '0;
    endcase
    o.busy = (st != IDLE);
    return o;
  endfunction

endpackage

// File: rtl/section1_ctrl_iter_counter16.sv
// 16-bit iteration counter with synchronous clear, increment enable
// and an equality flag against a limit.
module iter_counter16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        inc_i,
  input  logic [15:0] lim_i,
  output logic [15:0] cnt_o,
  output logic        hit_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == lim_i);

endmodule

// File: rtl/section1_ctrl.sv
// Section 1 sequencer: repeated-subtraction divide on the a0 register,
// driving mux selects / write enables and counting the quotient.
module section1_ctrl
  import section1_pkg::*;
#(
  parameter logic [15:0] MAX_ITER = S1_MAX_ITER_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        src_sel,
  input  logic        ge,
  input  logic        div_zero,
  output logic        CTRL1,
  output logic        CTRL2,
  output logic        CTRL6,
  output logic        CTRL7,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic        overflow,
  output logic        err
);

  s1_state_t state_q, state_d;
  logic      src_q, src_d;
  logic      err_q, err_d;
  logic      ovf_q, ovf_d;
  s1_out_t   out_q;
  logic      cnt_clr;
  logic      cnt_inc;
  logic      cnt_hit;

  iter_counter16 u_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .lim_i  (MAX_ITER),
    .cnt_o  (quotient),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          src_d   = src_sel;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        // Cap test precedes the increment, so quotient never wraps.
        unique case (1'b1)
          div_zero: begin
            err_d   = 1'b1;
            state_d = DONE;
          end
          (!div_zero && ge && cnt_hit): begin
            ovf_d   = 1'b1;
            state_d = DONE;
          end
          (!div_zero && ge && !cnt_hit): begin
            state_d = SUB;
          end
          default: state_d = DONE;
        endcase
      end
      SUB: begin
        cnt_inc = 1'b1;
        state_d = CHECK;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered
  // yet line up with the state they belong to.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      src_q   <= MUX_SEL_A0_IN;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      out_q   <= s1_decode(state_d, src_d);
    end
  end

  assign CTRL1    = out_q.ctrl1;
  assign CTRL2    = out_q.ctrl2;
  assign CTRL6    = out_q.ctrl6;
  assign CTRL7    = out_q.ctrl7;
  assign busy     = out_q.busy;
  assign done     = out_q.done;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: doc/section1_ctrl.md
# section1_ctrl

Control sequencer that drives the select and write-enable lines of datapath section 1, the a0 mux/register stage. It runs a repeated-subtraction division:
- load a0 from `a0_in` or `register_value`;
- repeatedly select the external subtractor result `sub` (a0 − divisor) into a0 while the comparator reports a0 ≥ divisor;
- count the subtractions as the quotient.

It sits directly upstream of section 1. On completion, a0 holds the remainder and `quotient` holds the count.

## Interface
Parameters:
- `MAX_ITER`, default 16'hFFFF: subtraction cap; hitting it ends the run with `overflow`.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin an operation; sampled in IDLE only.
- `src_sel`  in  1  dividend source: 0 = `a0_in`, 1 = `register_value`. Latched on accepted `start`.
- `ge`  in  1  comparator flag, a0_out ≥ divisor (combinational from section 1 `a0_out`).
- `div_zero`  in  1  divisor == 0 flag.
- `CTRL1`  out  1  section 1 mux_0 select.
- `CTRL2`  out  1  section 1 mux_1 select (1 = `sub`).
- `CTRL6`  out  1  quotient write-enable to downstream register file.
- `CTRL7`  out  1  section 1 a0 register write-enable.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `quotient`  out  16  subtraction count; holds its value after `done`.
- `overflow`  out  1  run ended by `MAX_ITER`; valid from `done` until the next `start`.
- `err`  out  1  run aborted because `div_zero` was set; valid from `done` until the next `start`.

## Operation
- States: IDLE, LOAD, CHECK, SUB, DONE. Outputs are a Moore decode of the state plus the latched `src_sel`.
- IDLE: all CTRL = 0. On `start` = 1: latch `src_sel`, clear `quotient`/`overflow`/`err`, go to LOAD.
- LOAD: CTRL1 = latched `src_sel`, CTRL2 = 0, CTRL7 = 1. a0 captures the dividend at the end of the cycle. Go to CHECK.
- CHECK: CTRL7 = 0. Transitions, in priority order:
  - `div_zero` → set `err`, go to DONE;
  - `ge` and `quotient` == `MAX_ITER` → set `overflow`, go to DONE;
  - `ge` → go to SUB;
  - else → go to DONE.
- SUB: CTRL1 = latched `src_sel`, CTRL2 = 1, CTRL7 = 1; `quotient` += 1. Go to CHECK.
- DONE: `done` = 1, CTRL6 = 1 for exactly this cycle; go to IDLE.
- Arithmetic: `quotient` is 16-bit unsigned and cannot wrap, because the cap check precedes the increment.
- `start` while `busy` is ignored, with no queuing.
- `div_zero` and `ge` are only evaluated in CHECK.

## Timing
- Reset (async assert, sync release):
  - state = IDLE;
  - CTRL1/2/6/7 = 0;
  - `busy`/`done`/`overflow`/`err` = 0;
  - `quotient` = 0.
- Reset mid-operation: all outputs return to reset values immediately. The a0 register content is then unspecified for the controller.
- Latency: with `start` sampled at cycle 0, LOAD = cycle 1, first CHECK = cycle 2, and each iteration costs 2 cycles (SUB + CHECK). `done` is at cycle 2q + 3.
- a0_out reflects the dividend in the first CHECK, and the new difference in every CHECK after a SUB. `ge` must settle within one cycle of a0_out changing.
- A new `start` is accepted in the cycle after DONE (IDLE). Minimum start-to-start spacing is 4 cycles.

## Structure
- Shared package `section1_pkg`:
  - state enum `s1_state_t` (IDLE, LOAD, CHECK, SUB, DONE);
  - `S1_MAX_ITER_DEFAULT`;
  - `MUX_SEL_A0_IN` = 0, `MUX_SEL_REG` = 1, `MUX_SEL_SUB` = 1.
- One natural sub-module: `iter_counter16`, a 16-bit counter with clear, increment enable, compare-to-limit output, async active-low reset. `section1_ctrl` holds the FSM and output decode.
- The bench instantiates `datapath_section1` together with a 16-bit subtractor and comparator for closed-loop checks.

## Test plan
- Dividend 7 on `a0_in`, divisor 2, `src_sel` = 0 → `quotient` = 3, a0_out = 1, `done` at cycle 9, `err` = `overflow` = 0.
- Dividend 0, divisor 5 → `quotient` = 0, a0_out = 0, `done` at cycle 3, no SUB cycles (CTRL2 never 1).
- Dividend 40 via `register_value` (`src_sel` = 1), divisor 0 → `err` = 1, `quotient` = 0, `done` at cycle 3, CTRL1 = 1 during LOAD.
- `MAX_ITER` = 4, dividend 100, divisor 1 → `overflow` = 1, `quotient` = 4, a0_out = 96, `done` at cycle 11.
- Start 7/2, pulse `start` again at cycle 4 → second start ignored, single `done` at cycle 9. A `start` at cycle 10 is accepted.
- Start 100/3, drop `RST_N` during the third SUB → all outputs 0 asynchronously, state IDLE. A fresh `start` after release gives `quotient` = 33, remainder 1.
